pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32: payload width in bits.
REQ-002 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into data registers on reset.
REQ-003 SHALL have parameter SKID, default 1: 1 = two-entry skid buffer with registered in_ready; 0 = single-entry stage with combinational in_ready.
REQ-004 SHALL have parameter CNT_W, default 32: stall counter width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-007 SHALL have port ce  input  1  global stage enable; 0 freezes the stage.
REQ-008 SHALL have port flush  input  1  synchronous discard of all held entries.
REQ-009 SHALL have port in_valid  input  1  upstream data valid.
REQ-010 SHALL have port in_data  input  WIDTH  upstream payload.
REQ-011 SHALL have port in_ready  output  1  stage can accept this cycle.
REQ-012 SHALL have port out_valid  output  1  out_data holds a valid entry.
REQ-013 SHALL have port out_data  output  WIDTH  head-entry payload.
REQ-014 SHALL have port out_ready  input  1  downstream accepts this cycle.
REQ-015 SHALL have port stall_cnt  output  CNT_W  saturating count of back-pressure cycles.

Function
REQ-016 SHALL define accept = in_valid & in_ready & ce and consume = out_valid & out_ready & ce.
REQ-017 SHALL hold state EMPTY, FULL or SKIDFULL; SKIDFULL SHALL be unreachable when SKID=0.
REQ-018 SHALL drive out_valid = (state != EMPTY) and out_data = main register, with no combinational path from in_data.
REQ-019 SKID=1: in_ready SHALL be (state != SKIDFULL) & ce & ~flush; SKID=0: in_ready SHALL be (~out_valid | out_ready) & ce & ~flush.
REQ-020 In EMPTY, accept SHALL load main and go to FULL; otherwise state SHALL remain EMPTY.
REQ-021 In FULL, accept&consume SHALL load main and stay FULL; accept only SHALL load skid and go to SKIDFULL; consume only SHALL go to EMPTY.
REQ-022 In SKIDFULL, consume SHALL copy skid to main and go to FULL; otherwise state SHALL remain SKIDFULL.
REQ-023 Latency SHALL be exactly one cycle from accept to out_valid when the stage was EMPTY.
REQ-024 ce=0 SHALL freeze state, main, skid and stall_cnt and force in_ready=0; out_valid and out_data SHALL hold.
REQ-025 flush=1 SHALL set state EMPTY on the next edge regardless of ce, in_valid and out_ready; data registers SHALL keep their contents and no accept SHALL occur that cycle.
REQ-026 Entries SHALL leave in the order accepted; none SHALL be dropped or duplicated except by flush.
REQ-027 stall_cnt SHALL increment by 1 on each cycle with out_valid & ~out_ready & ce & ~flush and SHALL saturate at 2^CNT_W-1.

Reset
REQ-028 rst SHALL immediately set state EMPTY, main and skid to RESET_VAL, and stall_cnt to 0, so that out_valid=0, in_ready=0 while rst is asserted, and out_data=RESET_VAL.
REQ-029 rst asserted mid-transfer SHALL discard all held entries without completing any handshake.

Structure
REQ-030 The state encoding (EMPTY=0, FULL=1, SKIDFULL=2) SHALL live in shared package pipe_pkg.
REQ-031 The saturating counter SHALL be a sub-module sat_counter (parameter CNT_W; ports clk, rst, en, cnt).

Verification
REQ-032 Reset then ce=1, in_valid=1, in_data=0x1234_5678, out_ready=1 -> out_valid=1 and out_data=0x1234_5678 next cycle; stall_cnt=0.
REQ-033 SKID=1, out_ready=0, push 0xA then 0xB -> state SKIDFULL, in_ready=0; raise out_ready -> outputs 0xA then 0xB on consecutive cycles; stall_cnt=2.
REQ-034 FULL holding 0x55 with ce=0 for 5 cycles and in_valid=1 -> out_data stays 0x55, in_ready=0, stall_cnt unchanged.
REQ-035 SKIDFULL, flush=1 with in_valid=1 -> out_valid=0 next cycle, in_ready=1, no entry accepted that cycle.
REQ-036 CNT_W=4, out_valid=1, out_ready=0 for 20 cycles -> stall_cnt saturates at 15.
REQ-037 SKID=0, 100 random pushes with random out_ready -> output sequence equals input sequence; rst pulse mid-stream -> out_valid=0 and out_data=RESET_VAL immediately.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline register stage.
// The stage state encoding is reused by anything that inspects the stage.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY    = 2'd0,
      FULL     = 2'd1,
      SKIDFULL = 2'd2
   } pipe_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-high reset.
// Holds at all-ones once reached.
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (en && (cnt_reg != {CNT_W{1'b1}})) begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

   assign cnt = cnt_reg;

endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline register stage: two-entry skid buffer (SKID=1) or single-entry
// stage (SKID=0), with global enable, flush and a back-pressure counter.
module pipe_skid_reg
   import pipe_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int               SKID      = 1,
   parameter int               CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ce,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] stall_cnt
);

   pipe_state_t      state_reg, state_next;
   logic [WIDTH-1:0] main_reg, main_next;
   logic [WIDTH-1:0] skid_reg, skid_next;
   logic             accept, consume, stall_en;

   assign out_valid = (state_reg != EMPTY);
   assign out_data  = main_reg;

   // in_ready is held low during reset so no handshake completes then.
   generate
      if (SKID != 0) begin : g_skid
         assign in_ready = (state_reg != SKIDFULL) & ce & ~flush & ~rst;
      end else begin : g_noskid
         assign in_ready = (~out_valid | out_ready) & ce & ~flush & ~rst;
      end
   endgenerate

   assign accept   = in_valid & in_ready & ce;
   assign consume  = out_valid & out_ready & ce;
   assign stall_en = out_valid & ~out_ready & ce & ~flush;

   always_comb begin
      state_next = state_reg;
      main_next  = main_reg;
      skid_next  = skid_reg;
      case (state_reg)
         EMPTY: begin
            if (accept) begin
               main_next  = in_data;
               state_next = FULL;
            end
         end
         FULL: begin
            if (accept && consume) begin
               main_next = in_data;
            end else if (accept) begin
               if (SKID != 0) begin
                  skid_next  = in_data;
                  state_next = SKIDFULL;
               end
            end else if (consume) begin
               state_next = EMPTY;
            end
         end
         SKIDFULL: begin
            if (consume) begin
               main_next  = skid_reg;
               state_next = FULL;
            end
         end
         default: state_next = EMPTY;
      endcase
      // Flush drops entries but leaves the data registers untouched.
      if (flush) begin
         state_next = EMPTY;
         main_next  = main_reg;
         skid_next  = skid_reg;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= EMPTY;
         main_reg  <= RESET_VAL;
         skid_reg  <= RESET_VAL;
      end else begin
         state_reg <= state_next;
         main_reg  <= main_next;
         skid_reg  <= skid_next;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .en  (stall_en),
      .cnt (stall_cnt)
   );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: a skid stage (SKID=1, CNT_W=4) and a single-entry stage
// (SKID=0) share one stimulus stream; each output set is checked separately.
module tb_pipe_skid_reg;

   logic        clk = 1'b0;
   logic        rst, ce, flush, in_valid, out_ready;
   logic [31:0] in_data;

   logic        a_in_ready, a_out_valid;
   logic [31:0] a_out_data;
   logic [3:0]  a_stall;
   logic        b_in_ready, b_out_valid;
   logic [31:0] b_out_data;
   logic [7:0]  b_stall;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   pipe_skid_reg #(
      .WIDTH(32), .RESET_VAL(32'h0), .SKID(1), .CNT_W(4)
   ) dut_a (
      .clk(clk), .rst(rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
      .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
      .stall_cnt(a_stall)
   );

   pipe_skid_reg #(
      .WIDTH(32), .RESET_VAL(32'hDEAD_BEEF), .SKID(0), .CNT_W(8)
   ) dut_b (
      .clk(clk), .rst(rst), .ce(ce), .flush(flush),
      .in_valid(in_valid), .in_data(in_data), .in_ready(b_in_ready),
      .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
      .stall_cnt(b_stall)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] q[$];
      int          pushes;

      rst = 1'b1; ce = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #2;
      check("rst_out_valid", a_out_valid, 0);
      check("rst_in_ready", a_in_ready, 0);
      check("rst_out_data", a_out_data, 32'h0);
      check("rst_stall", a_stall, 0);
      check("rst_b_out_data", b_out_data, 32'hDEAD_BEEF);
      step();
      rst = 1'b0;
      $display("reset released");

      // one-cycle latency through an empty stage
      in_valid = 1'b1; in_data = 32'h1234_5678; out_ready = 1'b1;
      #1;
      check("lat_in_ready", a_in_ready, 1);
      step();
      in_valid = 1'b0;
      check("lat_out_valid", a_out_valid, 1);
      check("lat_out_data", a_out_data, 32'h1234_5678);
      check("lat_stall", a_stall, 0);
      step();
      check("lat_drained", a_out_valid, 0);
      $display("latency transaction done");

      // fill both entries under back-pressure, then drain in order
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
      step();
      in_data = 32'hB;
      step();
      in_valid = 1'b0;
      check("skid_in_ready", a_in_ready, 0);
      check("skid_out_valid", a_out_valid, 1);
      check("skid_stall1", a_stall, 1);
      step();
      check("skid_stall2", a_stall, 2);
      out_ready = 1'b1;
      #1;
      check("skid_head_a", a_out_data, 32'hA);
      step();
      check("skid_valid_b", a_out_valid, 1);
      check("skid_head_b", a_out_data, 32'hB);
      step();
      check("skid_empty", a_out_valid, 0);
      check("skid_stall_final", a_stall, 2);
      $display("skid transaction done");

      // ce=0 freezes a full stage
      out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h55;
      step();
      ce = 1'b0; in_data = 32'h66;
      #1;
      check("ce_in_ready", a_in_ready, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         check("ce_out_data", a_out_data, 32'h55);
         check("ce_out_valid", a_out_valid, 1);
         check("ce_stall", a_stall, 2);
      end
      $display("ce freeze transaction done");

      // flush from SKIDFULL with in_valid high
      ce = 1'b1; in_data = 32'h77;
      step();
      check("fl_skidfull_ready", a_in_ready, 0);
      check("fl_stall_pre", a_stall, 3);
      flush = 1'b1; in_data = 32'h88;
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      check("fl_out_valid", a_out_valid, 0);
      check("fl_in_ready", a_in_ready, 1);
      check("fl_data_kept", a_out_data, 32'h55);
      check("fl_stall", a_stall, 3);
      step();
      check("fl_no_accept", a_out_valid, 0);
      flush = 1'b1; in_valid = 1'b1; in_data = 32'h90;
      #1;
      check("fl_empty_ready", a_in_ready, 0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_empty_no_accept", a_out_valid, 0);
      $display("flush transaction done");

      // saturation of the 4-bit stall counter
      in_valid = 1'b1; in_data = 32'h99; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 11; i++) step();
      check("sat_14", a_stall, 14);
      for (int i = 0; i < 9; i++) step();
      check("sat_15", a_stall, 15);
      check("sat_data", a_out_data, 32'h99);
      out_ready = 1'b1;
      step();
      check("sat_drain", a_out_valid, 0);
      $display("saturation transaction done");

      // clean reset of both stages, then random stream through SKID=0 stage
      out_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst2_b_valid", b_out_valid, 0);
      check("rst2_b_data", b_out_data, 32'hDEAD_BEEF);
      check("rst2_a_data", a_out_data, 32'h0);
      rst = 1'b0;
      step();

      pushes = 0;
      for (int cyc = 0; cyc < 600 && pushes < 100; cyc++) begin
         if (cyc == 60) begin
            in_valid = 1'b0; out_ready = 1'b0;
            rst = 1'b1;
            #1;
            check("mid_rst_valid", b_out_valid, 0);
            check("mid_rst_data", b_out_data, 32'hDEAD_BEEF);
            check("mid_rst_ready", b_in_ready, 0);
            rst = 1'b0;
            q.delete();
            $display("mid-stream reset at cycle %0d", cyc);
            step();
         end else begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd_valid", b_out_valid, (q.size() != 0));
            if (b_out_valid && q.size() != 0) begin
               check("rnd_data", b_out_data, q[0]);
               if (out_ready) void'(q.pop_front());
            end
            if (in_valid && b_in_ready) begin
               q.push_back(in_data);
               pushes++;
            end
            step();
         end
      end
      check("rnd_push_count", pushes, 100);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         check("drain_valid", b_out_valid, (q.size() != 0));
         if (b_out_valid && q.size() != 0) begin
            check("drain_data", b_out_data, q[0]);
            void'(q.pop_front());
         end
         step();
      end
      check("drain_empty", b_out_valid, 0);
      check("drain_model_empty", q.size(), 0);
      $display("random stream done: %0d pushes", pushes);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
